// File: rtl/pos2bin_serializer.sv
// Sticky positional-event collector that drains pending bit positions as binary indices over valid/ready.
// Define POS2BIN_SERIALIZER_RR_EN for round-robin selection; the default is fixed lowest-index priority.
module pos2bin_serializer #(
    parameter int POS_WIDTH = 16,
    parameter int BIN_WIDTH = $clog2(POS_WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [POS_WIDTH-1:0] pos_in,
    input  logic                 pos_valid,
    output logic [BIN_WIDTH-1:0] out_bin,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [POS_WIDTH-1:0] pending,
    output logic                 overflow
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t               state, state_nxt;
    logic                 accept, load, overflow_nxt;
    logic [BIN_WIDTH-1:0] sel;
    logic [POS_WIDTH-1:0] set_mask, clear_mask, pending_nxt;

`ifdef POS2BIN_SERIALIZER_RR_EN
    logic [BIN_WIDTH-1:0] rr_ptr;

    // Search starts at the pointer and wraps, so a repeatedly strobed low index cannot starve higher ones.
    function automatic logic [BIN_WIDTH-1:0] rr_select(input logic [POS_WIDTH-1:0] v,
                                                       input logic [BIN_WIDTH-1:0] ptr);
        logic found;
        int   j;
        found     = 1'b0;
        rr_select = '0;
        for (int i = 0; i < POS_WIDTH; i++) begin
            j = int'(ptr) + i;
            if (j >= POS_WIDTH) j = j - POS_WIDTH;
            if (!found && v[j]) begin
                found     = 1'b1;
                rr_select = BIN_WIDTH'(j);
            end
        end
    endfunction

    assign sel = rr_select(pending, rr_ptr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (load) begin
            rr_ptr <= (sel == BIN_WIDTH'(POS_WIDTH - 1)) ? '0 : sel + 1'b1;
        end
    end
`else
    function automatic logic [BIN_WIDTH-1:0] lowest_set(input logic [POS_WIDTH-1:0] v);
        lowest_set = '0;
        for (int i = POS_WIDTH - 1; i >= 0; i--) begin
            if (v[i]) lowest_set = BIN_WIDTH'(i);
        end
    endfunction

    assign sel = lowest_set(pending);
`endif

    assign out_valid = (state == FULL);
    assign accept    = (state == FULL) && out_ready;
    assign load      = ((state == EMPTY) || accept) && (pending != '0);

    // A strobe on the bit being loaded re-arms it instead of counting as a collision.
    always_comb begin
        clear_mask   = load ? (POS_WIDTH'(1) << sel) : '0;
        set_mask     = pos_valid ? pos_in : '0;
        pending_nxt  = (pending & ~clear_mask) | set_mask;
        overflow_nxt = |(set_mask & pending & ~clear_mask);
    end

    always_comb begin
        state_nxt = state;
        if (load) begin
            state_nxt = FULL;
        end else if (accept) begin
            state_nxt = EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= EMPTY;
            out_bin  <= '0;
            pending  <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= state_nxt;
            pending  <= pending_nxt;
            overflow <= overflow_nxt;
            if (load) out_bin <= sel;
        end
    end

endmodule

// File: tb/tb_pos2bin_serializer.sv
// Scoreboard bench for pos2bin_serializer: expected indices are queued at stimulus time and popped on each handshake.
module tb_pos2bin_serializer;

    localparam int POS_WIDTH = 16;
    localparam int BIN_WIDTH = $clog2(POS_WIDTH);

    logic                 clk;
    logic                 rst;
    logic [POS_WIDTH-1:0] pos_in;
    logic                 pos_valid;
    logic [BIN_WIDTH-1:0] out_bin;
    logic                 out_valid;
    logic                 out_ready;
    logic [POS_WIDTH-1:0] pending;
    logic                 overflow;

    int checks = 0;
    int errors = 0;
    int ovf_cnt = 0;
    int ovf_base;
    int exp_q[$];

    pos2bin_serializer #(.POS_WIDTH(POS_WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .pos_in    (pos_in),
        .pos_valid (pos_valid),
        .out_bin   (out_bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pending   (pending),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [POS_WIDTH-1:0] v);
        pos_in    = v;
        pos_valid = 1'b1;
        step();
        pos_valid = 1'b0;
        pos_in    = '0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < budget) begin
            step();
            n++;
        end
        check("drain_queue_empty", exp_q.size(), 0);
        check("drain_out_valid", out_valid, 0);
    endtask

    // Handshake monitor: the transfer completes at the next rising edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) check("unexpected_emit", out_bin, 32'hFFFF_FFFF);
            else check("emit", out_bin, exp_q.pop_front());
        end
        if (!rst && overflow) ovf_cnt++;
    end

    initial begin
        rst       = 1'b1;
        pos_in    = '0;
        pos_valid = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_pending", pending, 0);
        check("rst_out_bin", out_bin, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_overflow", overflow, 0);
        rst = 1'b0;

        // Single event
        out_ready = 1'b1;
        exp_q.push_back(5);
        drive(16'h0020);
        check("single_pending", pending, 16'h0020);
        check("single_valid_early", out_valid, 0);
        step();
        check("single_valid", out_valid, 1);
        check("single_bin", out_bin, 5);
        step();
        check("single_valid_drop", out_valid, 0);
        check("single_pending_clr", pending, 0);
        check("single_no_ovf", ovf_cnt, 0);

        // Multi-hot drain at full rate
        exp_q.push_back(0);
        exp_q.push_back(8);
        exp_q.push_back(15);
        drive(16'h8101);
        check("multi_pending", pending, 16'h8101);
        for (int k = 0; k < 3; k++) begin
            step();
            check("multi_valid", out_valid, 1);
        end
        step();
        check("multi_valid_drop", out_valid, 0);
        check("multi_pending_clr", pending, 0);

        // Backpressure
        out_ready = 1'b0;
        exp_q.push_back(0);
        exp_q.push_back(8);
        exp_q.push_back(15);
        drive(16'h8101);
        step();
        check("bp_valid", out_valid, 1);
        for (int k = 0; k < 5; k++) begin
            step();
            check("bp_hold_bin", out_bin, 0);
            check("bp_hold_pending", pending, 16'h8100);
        end
        out_ready = 1'b1;
        step();
        check("bp_bin8", out_bin, 8);
        step();
        check("bp_bin15", out_bin, 15);
        step();
        check("bp_valid_drop", out_valid, 0);

        // Overflow on a pending bit; re-strobe of the held index is not overflow
        out_ready = 1'b0;
        ovf_base  = ovf_cnt;
`ifdef POS2BIN_SERIALIZER_RR_EN
        exp_q.push_back(0);
        exp_q.push_back(3);
        exp_q.push_back(0);
`else
        exp_q.push_back(0);
        exp_q.push_back(0);
        exp_q.push_back(3);
`endif
        drive(16'h0009);
        step();
        check("ovf_held_bin", out_bin, 0);
        check("ovf_pending", pending, 16'h0008);
        drive(16'h0008);
        check("ovf_pulse", overflow, 1);
        check("ovf_merged", pending, 16'h0008);
        drive(16'h0001);
        check("ovf_pulse_end", overflow, 0);
        check("held_rearm_pending", pending, 16'h0009);
        out_ready = 1'b1;
        wait_drain(20);
        check("ovf_count", ovf_cnt - ovf_base, 1);

        // Same-cycle re-arm of the index being loaded
        ovf_base = ovf_cnt;
        exp_q.push_back(2);
        exp_q.push_back(2);
        drive(16'h0004);
        drive(16'h0004);
        check("rearm_bin", out_bin, 2);
        check("rearm_pending", pending, 16'h0004);
        check("rearm_no_ovf", overflow, 0);
        wait_drain(10);
        check("rearm_ovf_count", ovf_cnt - ovf_base, 0);

        // Asynchronous reset in the middle of a drain
        out_ready = 1'b0;
        drive(16'h8101);
        step();
        check("mid_pending", pending, 16'h8100);
        check("mid_valid", out_valid, 1);
        rst = 1'b1;
        #1;
        check("arst_pending", pending, 0);
        check("arst_out_bin", out_bin, 0);
        check("arst_out_valid", out_valid, 0);
        check("arst_overflow", overflow, 0);
        step();
        rst       = 1'b0;
        out_ready = 1'b1;
        repeat (5) step();
        check("post_rst_valid", out_valid, 0);
        check("post_rst_pending", pending, 0);

        // Selection order with a re-strobe of index 0 while index 1 loads
        ovf_base = ovf_cnt;
        exp_q.push_back(0);
        exp_q.push_back(1);
`ifdef POS2BIN_SERIALIZER_RR_EN
        exp_q.push_back(8);
        exp_q.push_back(0);
`else
        exp_q.push_back(0);
        exp_q.push_back(8);
`endif
        drive(16'h0103);
        step();
        check("sel_first_bin", out_bin, 0);
        drive(16'h0001);
        check("sel_second_bin", out_bin, 1);
        check("sel_pending", pending, 16'h0101);
        wait_drain(20);
        check("sel_ovf_count", ovf_cnt - ovf_base, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pos2bin_serializer.md
Name: pos2bin_serializer

Overview:
- Downstream consumer of positional (one-hot/multi-hot) vectors.
- Accumulates asserted bit positions into a sticky pending register.
- Drains pending positions one at a time as binary indices over a valid/ready interface.
- Sits after positional-code generators so that several events landing in one cycle are not lost.

Parameters:
- POS_WIDTH, 16, width of positional input vector; legal range 2 or more.
- BIN_WIDTH, $clog2(POS_WIDTH), width of emitted binary index.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous active-high reset.
- pos_in  input  POS_WIDTH  positional event vector, any number of bits set.
- pos_valid  input  1  strobe; pos_in sampled only when high.
- out_bin  output  BIN_WIDTH  emitted binary index of one pending position.
- out_valid  output  1  out_bin holds a valid index.
- out_ready  input  1  consumer accepts out_bin when out_valid and out_ready are both high.
- pending  output  POS_WIDTH  registered pending vector, excludes the index held in the output stage.
- overflow  output  1  one-cycle pulse: a strobed bit was already pending.

Behaviour:
- Reset (async assert, sync release): pending=0, out_bin=0, out_valid=0, overflow=0; RR pointer=0 when the macro is set.
- Output stage has two states, set by out_valid:
  - EMPTY (out_valid=0).
  - FULL (out_valid=1).
- load condition = (EMPTY or out_valid&&out_ready) and pending != 0, using the registered pending value.
- On load:
  - out_bin <= selected index.
  - out_valid <= 1.
  - That bit is cleared from pending.
- Handshake with no load: out_valid <= 0 (FULL -> EMPTY).
- While FULL and not accepted, out_bin is held stable.
- Pending next value = (pending & ~clear_mask) | (pos_valid ? pos_in : 0). The set term wins over clear on the same bit.
- Overflow pulse next cycle if pos_valid and (pos_in & pending & ~clear_mask) != 0. The event merges and is emitted once.
- Overflow rules:
  - A bit that matches the index being loaded in the same cycle is NOT overflow; it re-arms the bit.
  - A bit that matches the index currently held in out_bin is NOT overflow; it becomes pending again.
- Latency:
  - Strobe at edge N makes pending visible at N+1.
  - With pipeline idle, out_valid rises at N+2.
  - Sustained throughput is one index per cycle while out_ready=1.
- Selection: lowest set index of pending (fixed priority).
- Indices >= POS_WIDTH are never emitted. When POS_WIDTH is not a power of two, the unused out_bin codes never appear.
- Reset mid-operation drops all pending and held indices immediately. No pulse is generated on reset.

Optional Feature:
- Macro: POS2BIN_SERIALIZER_RR_EN.
- Defined: round-robin selection.
  - An RR pointer register holds (last loaded index + 1) mod POS_WIDTH and is updated on each load.
  - Search starts at the pointer and wraps past POS_WIDTH-1 to 0.
  - Guarantees no starvation under repeated strobes of low indices.
- Undefined: fixed lowest-index priority, and no pointer register exists.
- Ports, latency and overflow rules are identical in both builds.

Test Plan:
- Single event: pos_in=16'h0020 with pos_valid for 1 cycle, out_ready=1 -> out_bin=5, out_valid high exactly 1 cycle, 2 cycles after strobe; pending returns to 0; overflow never asserts.
- Multi-hot drain: pos_in=16'h8101 strobed, out_ready=1 -> out_bin sequence 0,8,15 on 3 consecutive cycles; then out_valid=0.
- Backpressure: same strobe, out_ready=0 for 5 cycles -> out_bin=0 held stable, pending=16'h8100. Then out_ready=1 -> 8,15 follow back-to-back.
- Overflow and same-cycle re-arm:
  - out_ready=0, pending bit 3 set; strobe 16'h0008 -> overflow pulses 1 cycle and index 3 is emitted once.
  - Strobe of the bit being loaded that cycle -> no overflow, and the index is emitted twice.
- Round-robin (macro defined):
  - Strobe 16'h0103, out_ready=1 -> 0,1,8.
  - Re-strobe 16'h0001 in the cycle index 1 loads -> 8 then 0.
  - Without the macro the same stimulus gives 0 then 8.
- Reset mid-drain: assert rst while pending=16'h8100 and out_valid=1 -> all outputs 0 asynchronously. After release, no index is emitted without a new strobe.
